// File: rtl/pipe_ctrl_if.sv
// ====================================================================
// pipe_ctrl_if: pipeline-control handshake bundle (pipeline side = master).
// Rev 1.0
// ====================================================================
`default_nettype none

interface pipe_ctrl_if #(
    parameter int NSTAGES = 4,
    parameter int REGW    = 5
);
    logic               mem_stall_i;
    logic               redirect_i;
    logic               ex_load_i;
    logic [REGW-1:0]    ex_rd_i;
    logic [REGW-1:0]    id_rs1_i;
    logic [REGW-1:0]    id_rs2_i;
    logic               id_rs1_use_i;
    logic               id_rs2_use_i;
    logic               imem_req_i;
    logic               imem_resp_i;
    logic               pc_stall_o;
    logic [NSTAGES-1:0] stall_o;
    logic [NSTAGES-1:0] flush_o;
    logic               imem_req_ok_o;
    logic               imem_discard_o;

    modport slave (
        input  mem_stall_i, redirect_i, ex_load_i, ex_rd_i, id_rs1_i, id_rs2_i,
               id_rs1_use_i, id_rs2_use_i, imem_req_i, imem_resp_i,
        output pc_stall_o, stall_o, flush_o, imem_req_ok_o, imem_discard_o
    );

    modport master (
        output mem_stall_i, redirect_i, ex_load_i, ex_rd_i, id_rs1_i, id_rs2_i,
               id_rs1_use_i, id_rs2_use_i, imem_req_i, imem_resp_i,
        input  pc_stall_o, stall_o, flush_o, imem_req_ok_o, imem_discard_o
    );
endinterface

`default_nettype wire

// File: rtl/pipe_ctrl.sv
// ====================================================================
// pipe_ctrl: stall/flush priority and I$ stale-response tracking; PIPE_CTRL_PERF_EN adds perf counters.
// Rev 1.0
// ====================================================================
`default_nettype none

module pipe_ctrl #(
    parameter int NSTAGES   = 4,
    parameter int EX_IDX    = 1,
    parameter int MEM_IDX   = 2,
    parameter int MAX_OUTST = 2,
    parameter int REGW      = 5
) (
    input  wire logic   clk_i,
    input  wire logic   rst_i,
    pipe_ctrl_if.slave  bus
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [31:0] perf_stall_cnt_o,
    output logic [31:0] perf_flush_cnt_o,
    output logic [31:0] perf_discard_cnt_o
`endif
);
    localparam int            OW     = $clog2(MAX_OUTST + 1);
    localparam logic [OW-1:0] C_MAXO = OW'(MAX_OUTST);

    localparam logic [0:0] S_RUN   = 1'b0;
    localparam logic [0:0] S_DRAIN = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [OW-1:0] outst_q, outst_d;
    logic [OW-1:0] disc_q,  disc_d;
    logic [OW-1:0] stale;
    logic          load_use;
    logic          redirect_eff;

    assign load_use = bus.ex_load_i && (bus.ex_rd_i != '0) &&
                      ((bus.id_rs1_use_i && (bus.id_rs1_i == bus.ex_rd_i)) ||
                       (bus.id_rs2_use_i && (bus.id_rs2_i == bus.ex_rd_i)));

    assign redirect_eff = bus.redirect_i && !bus.mem_stall_i;

    always_comb begin
        bus.pc_stall_o = 1'b0;
        bus.stall_o    = '0;
        bus.flush_o    = '0;
        if (rst_i) begin
            bus.pc_stall_o = 1'b0;
        end else if (bus.mem_stall_i) begin
            bus.pc_stall_o = 1'b1;
            for (int i = 0; i < NSTAGES; i++) begin
                if (i <= MEM_IDX)     bus.stall_o[i] = 1'b1;
                if (i == MEM_IDX + 1) bus.flush_o[i] = 1'b1;
            end
        end else if (bus.redirect_i) begin
            for (int i = 0; i < NSTAGES; i++) begin
                if (i <= EX_IDX) bus.flush_o[i] = 1'b1;
            end
        end else if (load_use) begin
            bus.pc_stall_o = 1'b1;
            for (int i = 0; i < NSTAGES; i++) begin
                if (i < EX_IDX)  bus.stall_o[i] = 1'b1;
                if (i == EX_IDX) bus.flush_o[i] = 1'b1;
            end
        end
    end

    assign bus.imem_req_ok_o  = rst_i || (outst_q < C_MAXO) || bus.imem_resp_i;
    assign bus.imem_discard_o = !rst_i && (state_q == S_DRAIN) && bus.imem_resp_i;

    // Requests issued this cycle target the new PC, so only pre-existing
    // requests minus any retired now are stale; this also covers redirect in DRAIN.
    always_comb begin
        outst_d = outst_q + OW'(bus.imem_req_i) - OW'(bus.imem_resp_i);
        stale   = outst_q - OW'(bus.imem_resp_i);
        state_d = state_q;
        disc_d  = disc_q;
        if (redirect_eff) begin
            disc_d  = stale;
            state_d = (stale != '0) ? S_DRAIN : S_RUN;
        end else if (state_q == S_DRAIN) begin
            disc_d = disc_q - OW'(bus.imem_resp_i);
            if (disc_d == '0) state_d = S_RUN;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_RUN;
            outst_q <= '0;
            disc_q  <= '0;
        end else begin
            state_q <= state_d;
            outst_q <= outst_d;
            disc_q  <= disc_d;
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] perf_stall_q, perf_flush_q, perf_disc_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
            perf_disc_q  <= '0;
        end else begin
            if (bus.pc_stall_o && (perf_stall_q != '1))     perf_stall_q <= perf_stall_q + 32'd1;
            if ((|bus.flush_o) && (perf_flush_q != '1))     perf_flush_q <= perf_flush_q + 32'd1;
            if (bus.imem_discard_o && (perf_disc_q != '1))  perf_disc_q  <= perf_disc_q + 32'd1;
        end
    end

    assign perf_stall_cnt_o   = perf_stall_q;
    assign perf_flush_cnt_o   = perf_flush_q;
    assign perf_discard_cnt_o = perf_disc_q;
`endif

    a_req_ok: assert property (@(posedge clk_i) disable iff (rst_i)
        bus.imem_req_i |-> bus.imem_req_ok_o);
    a_resp_outst: assert property (@(posedge clk_i) disable iff (rst_i)
        bus.imem_resp_i |-> (outst_q != '0));

endmodule

`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
// ====================================================================
// tb_pipe_ctrl: table vectors plus multi-cycle I$ drain/reset sequences, scoreboard-checked.
// Rev 1.0
// ====================================================================
`default_nettype none

module tb_pipe_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pipe_ctrl_if #(.NSTAGES(4), .REGW(5)) bus ();

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] p_stall, p_flush, p_disc;
`endif

    pipe_ctrl #(.NSTAGES(4), .EX_IDX(1), .MEM_IDX(2), .MAX_OUTST(2), .REGW(5)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
`ifdef PIPE_CTRL_PERF_EN
        ,
        .perf_stall_cnt_o   (p_stall),
        .perf_flush_cnt_o   (p_flush),
        .perf_discard_cnt_o (p_disc)
`endif
    );

    typedef struct {
        logic       ms, rd, ld;
        logic [4:0] exrd, rs1, rs2;
        logic       u1, u2;
        logic       pcs;
        logic [3:0] st, fl;
    } vec_t;

    typedef struct {
        string      tag;
        logic       pcs;
        logic [3:0] st, fl;
        logic       ok, dis;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, want);
        end
    endtask

    task automatic set_in(input logic ms, input logic rd, input logic ld, input logic [4:0] exrd,
                          input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                          input logic u2, input logic req, input logic resp);
        bus.mem_stall_i  = ms;
        bus.redirect_i   = rd;
        bus.ex_load_i    = ld;
        bus.ex_rd_i      = exrd;
        bus.id_rs1_i     = rs1;
        bus.id_rs2_i     = rs2;
        bus.id_rs1_use_i = u1;
        bus.id_rs2_use_i = u2;
        bus.imem_req_i   = req;
        bus.imem_resp_i  = resp;
    endtask

    task automatic push(input string tag, input logic pcs, input logic [3:0] st,
                        input logic [3:0] fl, input logic ok, input logic dis);
        exp_t e;
        e.tag = tag; e.pcs = pcs; e.st = st; e.fl = fl; e.ok = ok; e.dis = dis;
        sb.push_back(e);
    endtask

    task automatic pop_cmp();
        exp_t e;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk({e.tag, ".pc_stall"}, 32'(bus.pc_stall_o),     32'(e.pcs));
            chk({e.tag, ".stall"},    32'(bus.stall_o),        32'(e.st));
            chk({e.tag, ".flush"},    32'(bus.flush_o),        32'(e.fl));
            chk({e.tag, ".req_ok"},   32'(bus.imem_req_ok_o),  32'(e.ok));
            chk({e.tag, ".discard"},  32'(bus.imem_discard_o), 32'(e.dis));
        end
    endtask

    // Check at the falling edge, then move on to 1 time unit after the next rising edge.
    task automatic step();
        @(negedge clk);
        pop_cmp();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input string tag, input logic req, input logic resp, input logic rd,
                       input logic ok, input logic dis, input logic [3:0] fl);
        set_in(1'b0, rd, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, req, resp);
        push(tag, 1'b0, 4'b0000, fl, ok, dis);
        step();
    endtask

    vec_t tbl[13];

    initial begin
        //          ms    rd    ld    exrd   rs1    rs2    u1    u2    pcs   st       fl
        tbl[0]  = '{1'b0, 1'b0, 1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b1, 4'b0111, 4'b1000};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b1, 4'b0111, 4'b1000};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b1, 4'b0111, 4'b1000};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000};
        tbl[5]  = '{1'b0, 1'b0, 1'b1, 5'd5,  5'd0,  5'd5,  1'b0, 1'b1, 1'b1, 4'b0001, 4'b0010};
        tbl[6]  = '{1'b0, 1'b0, 1'b1, 5'd0,  5'd0,  5'd0,  1'b1, 1'b1, 1'b0, 4'b0000, 4'b0000};
        tbl[7]  = '{1'b0, 1'b0, 1'b1, 5'd5,  5'd5,  5'd3,  1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000};
        tbl[8]  = '{1'b0, 1'b0, 1'b1, 5'd7,  5'd7,  5'd0,  1'b1, 1'b0, 1'b1, 4'b0001, 4'b0010};
        tbl[9]  = '{1'b1, 1'b1, 1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b1, 4'b0111, 4'b1000};
        tbl[10] = '{1'b0, 1'b1, 1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 4'b0000, 4'b0011};
        tbl[11] = '{1'b0, 1'b1, 1'b1, 5'd9,  5'd9,  5'd0,  1'b1, 1'b0, 1'b0, 4'b0000, 4'b0011};
        tbl[12] = '{1'b1, 1'b0, 1'b1, 5'd9,  5'd9,  5'd0,  1'b1, 1'b0, 1'b1, 4'b0111, 4'b1000};

        // Reset with hazard-producing inputs: outputs must still read zero.
        set_in(1'b1, 1'b1, 1'b1, 5'd5, 5'd5, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
        push("reset", 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0);
        #2;
        pop_cmp();
        repeat (2) @(posedge clk);
        #1;
        set_in(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;

        foreach (tbl[i]) begin
            set_in(tbl[i].ms, tbl[i].rd, tbl[i].ld, tbl[i].exrd, tbl[i].rs1, tbl[i].rs2,
                   tbl[i].u1, tbl[i].u2, 1'b0, 1'b0);
            push($sformatf("vec%0d", i), tbl[i].pcs, tbl[i].st, tbl[i].fl, 1'b1, 1'b0);
            step();
        end

        // Fill to MAX_OUTST, then redirect drains exactly two stale responses.
        cyc("fill1",     1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000);
        cyc("fill2",     1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000);
        cyc("full",      1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
        cyc("full_resp", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000);
        cyc("redir",     1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0011);
        cyc("drain1",    1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'b0000);
        cyc("drain2",    1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'b0000);
        cyc("run_req",   1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000);
        cyc("run_resp",  1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000);

        // Request in the redirect cycle is fresh.
        cyc("nr_req",    1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000);
        cyc("nr_redir",  1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0011);
        cyc("nr_stale",  1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'b0000);
        cyc("nr_fresh",  1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000);

        // Redirect inside DRAIN folds the fresh request into the stale count.
        cyc("dr_req1",   1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000);
        cyc("dr_req2",   1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000);
        cyc("dr_redir1", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0011);
        cyc("dr_swap",   1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'b0000);
        cyc("dr_redir2", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0011);
        cyc("dr_d1",     1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'b0000);
        cyc("dr_d2",     1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'b0000);

        // Redirect blocked by mem stall is taken once the stall drops.
        cyc("ms_req",    1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000);
        set_in(1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        push("ms_redir", 1'b1, 4'b0111, 4'b1000, 1'b1, 1'b0);
        step();
        cyc("ms_after",  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0011);
        cyc("ms_stale",  1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'b0000);

        // Asynchronous reset in the middle of DRAIN.
        cyc("rs_req1",   1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000);
        cyc("rs_req2",   1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000);
        cyc("rs_redir",  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0011);
        set_in(1'b1, 1'b1, 1'b1, 5'd5, 5'd5, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1);
        #1;
        rst = 1'b1;
        push("rs_async", 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0);
        #1;
        pop_cmp();
        @(posedge clk);
        #1;
        set_in(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        push("rs_hold", 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0);
        #1;
        pop_cmp();
        rst = 1'b0;
        @(posedge clk);
        #1;
        cyc("rs_run_req",  1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000);
        cyc("rs_run_resp", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000);

        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end
endmodule

`default_nettype wire
